// File: rtl/decryption_cfg_scheduler.sv
`default_nettype none
//==============================================================================
// Module   : decryption_cfg_scheduler
// Function : Stalls the master input, waits for the cipher engines to drain,
//            then programs the key and select registers with done/error retry.
// Option   : READBACK_VERIFY_EN - verify every write with a register readback.
// Revision : 1.0 - initial release
//==============================================================================
module decryption_cfg_scheduler #(
    parameter int                    ADDR_WIDTH   = 8,
    parameter int                    REG_WIDTH    = 16,
    parameter logic [ADDR_WIDTH-1:0] SELECT_ADDR  = 8'h00,
    parameter logic [ADDR_WIDTH-1:0] CAESAR_ADDR  = 8'h10,
    parameter logic [ADDR_WIDTH-1:0] SCYTALE_ADDR = 8'h12,
    parameter logic [ADDR_WIDTH-1:0] ZIGZAG_ADDR  = 8'h14,
    parameter int                    DRAIN_CYCLES = 4,
    parameter int                    TIMEOUT      = 16,
    parameter int                    MAX_RETRY    = 2
) (
    input  logic                  clk_sys,
    input  logic                  rst,
    input  logic                  cfg_req,
    input  logic [1:0]            cfg_mode,
    input  logic [REG_WIDTH-1:0]  cfg_key,
    output logic                  cfg_ready,
    output logic                  cfg_done,
    output logic                  cfg_fail,
    output logic                  hold_o,
    input  logic                  valid_i,
    input  logic                  busy,
    output logic [ADDR_WIDTH-1:0] addr,
    output logic                  write,
    output logic                  read,
    output logic [REG_WIDTH-1:0]  wdata,
    input  logic [REG_WIDTH-1:0]  rdata,
    input  logic                  done,
    input  logic                  error,
    output logic [1:0]            cur_mode
);

    localparam logic [2:0] c_st_idle    = 3'd0;
    localparam logic [2:0] c_st_drain   = 3'd1;
    localparam logic [2:0] c_st_wr      = 3'd2;
    localparam logic [2:0] c_st_wait_wr = 3'd3;
    localparam logic [2:0] c_st_commit  = 3'd4;
    localparam logic [2:0] c_st_fail    = 3'd5;
`ifdef READBACK_VERIFY_EN
    localparam logic [2:0] c_st_rd      = 3'd6;
    localparam logic [2:0] c_st_wait_rd = 3'd7;
`endif

    localparam logic [3:0] c_drain_last = 4'(DRAIN_CYCLES - 1);
    localparam logic [7:0] c_wait_last  = 8'(TIMEOUT - 1);
    localparam logic [1:0] c_max_retry  = 2'(MAX_RETRY);

    logic [2:0]            r_state;
    logic [1:0]            r_mode;
    logic [REG_WIDTH-1:0]  r_key;
    logic                  r_phase;     // 0: key register, 1: select register
    logic [3:0]            r_idle_cnt;
    logic [7:0]            r_wait_cnt;  // counts from the strobe cycle
    logic [1:0]            r_retry;
    logic                  r_ready;
    logic                  r_done;
    logic                  r_fail;
    logic                  r_hold;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic                  r_write;
    logic [REG_WIDTH-1:0]  r_wdata;
    logic [1:0]            r_cur_mode;

    logic [ADDR_WIDTH-1:0] w_key_addr;
    logic [REG_WIDTH-1:0]  w_sel_data;
    logic                  w_in_wait;
    logic                  w_data_ok;
    logic                  w_timeout;
    logic                  w_acc_ok;
    logic                  w_acc_bad;

    always_comb begin
        w_key_addr = ZIGZAG_ADDR;
        case (r_mode)
            2'd0:    w_key_addr = CAESAR_ADDR;
            2'd1:    w_key_addr = SCYTALE_ADDR;
            default: w_key_addr = ZIGZAG_ADDR;
        endcase
    end

    assign w_sel_data = {{(REG_WIDTH-2){1'b0}}, r_mode};

`ifdef READBACK_VERIFY_EN
    logic r_read;

    assign w_in_wait = (r_state == c_st_wait_wr) || (r_state == c_st_wait_rd);
    assign w_data_ok = !error && ((r_state == c_st_wait_wr) || (rdata == r_wdata));
    assign read      = r_read;
`else
    logic w_rdata_unused;

    assign w_in_wait      = (r_state == c_st_wait_wr);
    assign w_data_ok      = !error;
    assign w_rdata_unused = ^rdata;
    assign read           = 1'b0;
`endif

    // A done in the same cycle as the timeout still counts as a response
    assign w_timeout = (r_wait_cnt == c_wait_last);
    assign w_acc_ok  = done && w_data_ok;
    assign w_acc_bad = done ? !w_data_ok : w_timeout;

    always_ff @(posedge clk_sys or posedge rst) begin
        if (rst) begin
            r_state    <= c_st_idle;
            r_mode     <= 2'd0;
            r_key      <= '0;
            r_phase    <= 1'b0;
            r_idle_cnt <= 4'd0;
            r_wait_cnt <= 8'd0;
            r_retry    <= 2'd0;
            r_ready    <= 1'b1;
            r_done     <= 1'b0;
            r_fail     <= 1'b0;
            r_hold     <= 1'b0;
            r_addr     <= '0;
            r_write    <= 1'b0;
            r_wdata    <= '0;
            r_cur_mode <= 2'd0;
`ifdef READBACK_VERIFY_EN
            r_read     <= 1'b0;
`endif
        end else begin
            r_write <= 1'b0;
            r_done  <= 1'b0;
            r_fail  <= 1'b0;
`ifdef READBACK_VERIFY_EN
            r_read  <= 1'b0;
`endif
            if (w_in_wait) begin
                if (w_acc_ok) begin
`ifdef READBACK_VERIFY_EN
                    if (r_state == c_st_wait_wr) begin
                        r_state <= c_st_rd;
                        r_read  <= 1'b1;
                    end else
`endif
                    if (!r_phase) begin
                        r_phase <= 1'b1;
                        r_retry <= 2'd0;
                        r_addr  <= SELECT_ADDR;
                        r_wdata <= w_sel_data;
                        r_state <= c_st_wr;
                        r_write <= 1'b1;
                    end else begin
                        r_state    <= c_st_commit;
                        r_done     <= 1'b1;
                        r_hold     <= 1'b0;
                        r_cur_mode <= r_mode;
                    end
                end else if (w_acc_bad) begin
                    // Every retry restarts at the write; addr/wdata are still held
                    if (r_retry < c_max_retry) begin
                        r_retry <= r_retry + 2'd1;
                        r_state <= c_st_wr;
                        r_write <= 1'b1;
                    end else begin
                        r_state <= c_st_fail;
                        r_fail  <= 1'b1;
                        r_hold  <= 1'b0;
                    end
                end else begin
                    r_wait_cnt <= r_wait_cnt + 8'd1;
                end
            end else begin
                case (r_state)
                    c_st_idle: begin
                        if (cfg_req) begin
                            r_mode <= cfg_mode;
                            r_key  <= cfg_key;
                            if (cfg_mode == 2'd3) begin
                                r_fail <= 1'b1;
                            end else begin
                                r_state    <= c_st_drain;
                                r_ready    <= 1'b0;
                                r_hold     <= 1'b1;
                                r_idle_cnt <= 4'd0;
                            end
                        end
                    end
                    c_st_drain: begin
                        if (!busy && !valid_i) begin
                            if (r_idle_cnt == c_drain_last) begin
                                r_state <= c_st_wr;
                                r_write <= 1'b1;
                                r_addr  <= w_key_addr;
                                r_wdata <= r_key;
                                r_phase <= 1'b0;
                                r_retry <= 2'd0;
                            end else begin
                                r_idle_cnt <= r_idle_cnt + 4'd1;
                            end
                        end else begin
                            r_idle_cnt <= 4'd0;
                        end
                    end
                    c_st_wr: begin
                        r_state    <= c_st_wait_wr;
                        r_wait_cnt <= 8'd1;
                    end
`ifdef READBACK_VERIFY_EN
                    c_st_rd: begin
                        r_state    <= c_st_wait_rd;
                        r_wait_cnt <= 8'd1;
                    end
`endif
                    c_st_commit, c_st_fail: begin
                        r_state <= c_st_idle;
                        r_ready <= 1'b1;
                    end
                    default: begin
                        r_state <= c_st_idle;
                        r_ready <= 1'b1;
                        r_hold  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign cfg_ready = r_ready;
    assign cfg_done  = r_done;
    assign cfg_fail  = r_fail;
    assign hold_o    = r_hold;
    assign addr      = r_addr;
    assign write     = r_write;
    assign wdata     = r_wdata;
    assign cur_mode  = r_cur_mode;

endmodule
`default_nettype wire

// File: tb/tb_decryption_cfg_scheduler.sv
`default_nettype none
//==============================================================================
// Module   : tb_decryption_cfg_scheduler
// Function : Scoreboard bench for decryption_cfg_scheduler with a regfile
//            responder model (error, no-response and readback corruption).
// Revision : 1.0 - initial release
//==============================================================================
module tb_decryption_cfg_scheduler;

    localparam int         DRAIN   = 4;
    localparam int         TIMEOUT = 16;
    localparam int         RETRY   = 2;
    localparam logic [7:0] SEL_A   = 8'h00;
    localparam logic [7:0] CAE_A   = 8'h10;
    localparam logic [7:0] SCY_A   = 8'h12;
    localparam logic [7:0] ZIG_A   = 8'h14;
`ifdef READBACK_VERIFY_EN
    localparam int         RB_EXTRA = 4;
`else
    localparam int         RB_EXTRA = 0;
`endif

    logic        clk_sys = 1'b0;
    logic        rst     = 1'b1;
    logic        cfg_req = 1'b0;
    logic [1:0]  cfg_mode = 2'd0;
    logic [15:0] cfg_key  = 16'd0;
    logic        cfg_ready, cfg_done, cfg_fail, hold_o;
    logic        valid_i = 1'b0;
    logic        busy    = 1'b0;
    logic [7:0]  addr;
    logic        write, read;
    logic [15:0] wdata;
    logic [15:0] rdata = 16'd0;
    logic        done  = 1'b0;
    logic        error = 1'b0;
    logic [1:0]  cur_mode;

    typedef struct {
        bit          is_rd;
        logic [7:0]  a;
        logic [15:0] d;
    } acc_t;

    acc_t        exp_q[$];
    acc_t        mon_e;
    int          strobe_cyc[$];
    int          checks = 0, failures = 0, cyc = 0, n_done = 0, n_fail = 0;
    int          err_budget = 0, mis_budget = 0;
    bit          no_resp = 1'b0, pending = 1'b0, pend_rd = 1'b0;
    logic [15:0] mem_d = 16'd0;

    decryption_cfg_scheduler #(
        .ADDR_WIDTH(8), .REG_WIDTH(16),
        .SELECT_ADDR(SEL_A), .CAESAR_ADDR(CAE_A), .SCYTALE_ADDR(SCY_A), .ZIGZAG_ADDR(ZIG_A),
        .DRAIN_CYCLES(DRAIN), .TIMEOUT(TIMEOUT), .MAX_RETRY(RETRY)
    ) dut (
        .clk_sys(clk_sys), .rst(rst), .cfg_req(cfg_req), .cfg_mode(cfg_mode),
        .cfg_key(cfg_key), .cfg_ready(cfg_ready), .cfg_done(cfg_done),
        .cfg_fail(cfg_fail), .hold_o(hold_o), .valid_i(valid_i), .busy(busy),
        .addr(addr), .write(write), .read(read), .wdata(wdata), .rdata(rdata),
        .done(done), .error(error), .cur_mode(cur_mode)
    );

    always #5 clk_sys = ~clk_sys;
    always @(posedge clk_sys) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Regfile model: answers each strobe with done one cycle later
    always @(posedge clk_sys) begin
        #1;
        done  = 1'b0;
        error = 1'b0;
        if (rst) begin
            pending = 1'b0;
        end else begin
            if (pending) begin
                done = 1'b1;
                if (pend_rd) begin
                    rdata = (mis_budget > 0) ? ~mem_d : mem_d;
                    if (mis_budget > 0) mis_budget--;
                end else if (err_budget > 0) begin
                    error = 1'b1;
                    err_budget--;
                end
                pending = 1'b0;
            end
            if ((write || read) && !no_resp) begin
                pending = 1'b1;
                pend_rd = read;
                if (write) mem_d = wdata;
            end
        end
    end

    // Scoreboard: every strobe must match the head of the expected queue
    always @(negedge clk_sys) begin
        if (!rst) begin
            if (write || read) begin
                if (write) strobe_cyc.push_back(cyc);
                check_eq("strobe_exclusive", write & read, 0);
                check_eq("strobe_expected", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) begin
                    mon_e = exp_q.pop_front();
                    check_eq("strobe_kind", read, mon_e.is_rd);
                    check_eq("strobe_addr", addr, mon_e.a);
                    check_eq("strobe_wdata", wdata, mon_e.d);
                end
            end
            if (cfg_done) n_done++;
            if (cfg_fail) n_fail++;
        end
    end

    task automatic push_wr(input logic [7:0] a, input logic [15:0] d);
        exp_q.push_back('{1'b0, a, d});
`ifdef READBACK_VERIFY_EN
        exp_q.push_back('{1'b1, a, d});
`endif
    endtask

    task automatic push_raw(input logic [7:0] a, input logic [15:0] d);
        exp_q.push_back('{1'b0, a, d});
    endtask

    task automatic start_req(input logic [1:0] m, input logic [15:0] k, output int acc);
        @(negedge clk_sys);
        cfg_req  = 1'b1;
        cfg_mode = m;
        cfg_key  = k;
        acc      = cyc;
        @(negedge clk_sys);
        cfg_req  = 1'b0;
    endtask

    task automatic wait_result(input string tag, input bit exp_done, input int exp_cyc);
        int n = 0;
        while (!(cfg_done || cfg_fail) && n < 300) begin
            @(negedge clk_sys);
            n++;
        end
        check_eq({tag, "_finished"}, n < 300, 1);
        check_eq({tag, "_done"}, cfg_done, exp_done);
        check_eq({tag, "_fail"}, cfg_fail, !exp_done);
        if (exp_cyc >= 0) check_eq({tag, "_cycle"}, cyc, exp_cyc);
        check_eq({tag, "_hold_low"}, hold_o, 0);
        @(negedge clk_sys);
        check_eq({tag, "_pulse_1cyc"}, cfg_done | cfg_fail, 0);
        check_eq({tag, "_ready"}, cfg_ready, 1);
        check_eq({tag, "_queue_empty"}, exp_q.size(), 0);
    endtask

    initial begin
        int a, n, d0, f0;
        repeat (3) @(negedge clk_sys);
        check_eq("rst_ready", cfg_ready, 1);
        check_eq("rst_done", cfg_done, 0);
        check_eq("rst_fail", cfg_fail, 0);
        check_eq("rst_hold", hold_o, 0);
        check_eq("rst_addr", addr, 0);
        check_eq("rst_write", write, 0);
        check_eq("rst_read", read, 0);
        check_eq("rst_wdata", wdata, 0);
        check_eq("rst_cur_mode", cur_mode, 0);
        rst = 1'b0;

        // Clean Caesar request
        push_wr(CAE_A, 16'h0003);
        push_wr(SEL_A, 16'h0000);
        start_req(2'd0, 16'h0003, a);
        wait_result("basic", 1'b1, a + DRAIN + 5 + RB_EXTRA);
        check_eq("basic_cur_mode", cur_mode, 0);

        // Scytale with an error on the first key write
        d0 = n_done;
        err_budget = 1;
        push_raw(SCY_A, 16'hBEEF);
        push_wr(SCY_A, 16'hBEEF);
        push_wr(SEL_A, 16'h0001);
        start_req(2'd1, 16'hBEEF, a);
        wait_result("err_retry", 1'b1, a + DRAIN + 7 + RB_EXTRA);
        check_eq("err_retry_cur_mode", cur_mode, 1);
        check_eq("err_retry_done_count", n_done - d0, 1);

        // Regfile never answers: initial try plus RETRY retries, then fail
        no_resp = 1'b1;
        strobe_cyc.delete();
        for (int i = 0; i <= RETRY; i++) push_raw(CAE_A, 16'h00AB);
        start_req(2'd0, 16'h00AB, a);
        wait_result("timeout", 1'b0, a + DRAIN + 1 + (RETRY + 1) * TIMEOUT);
        check_eq("timeout_strobes", strobe_cyc.size(), RETRY + 1);
        if (strobe_cyc.size() == RETRY + 1)
            for (int i = 1; i <= RETRY; i++)
                check_eq("timeout_spacing", strobe_cyc[i] - strobe_cyc[i-1], TIMEOUT);
        check_eq("timeout_cur_mode", cur_mode, 1);
        no_resp = 1'b0;

        // Illegal mode: no hold, no strobe, fail next cycle
        f0 = n_fail;
        start_req(2'd3, 16'h7777, a);
        wait_result("illegal", 1'b0, a + 1);
        check_eq("illegal_fail_count", n_fail - f0, 1);
        check_eq("illegal_cur_mode", cur_mode, 1);

        // ZigZag with busy held, a busy glitch and a valid_i blip during drain
        push_wr(ZIG_A, 16'h5A5A);
        push_wr(SEL_A, 16'h0002);
        strobe_cyc.delete();
        busy = 1'b1;
        start_req(2'd2, 16'h5A5A, a);
        for (int k = 1; k <= 19; k++) begin
            busy    = (k <= 10) || (k == 13);
            valid_i = (k == 15);
            check_eq("drain_hold", hold_o, 1);
            @(negedge clk_sys);
        end
        busy    = 1'b0;
        valid_i = 1'b0;
        wait_result("busy", 1'b1, a + 16 + DRAIN + 4 + RB_EXTRA);
        check_eq("busy_first_write", (strobe_cyc.size() > 0) ? strobe_cyc[0] : -1, a + 16 + DRAIN);
        check_eq("busy_cur_mode", cur_mode, 2);

        // Reset while waiting for the select write to complete
        push_wr(SCY_A, 16'h0055);
        push_raw(SEL_A, 16'h0001);
        start_req(2'd1, 16'h0055, a);
        n = 0;
        while (!(write && addr == SEL_A) && n < 100) begin
            @(negedge clk_sys);
            n++;
        end
        check_eq("arst_reach_select", n < 100, 1);
        @(posedge clk_sys);
        #2 rst = 1'b1;
        #1;
        check_eq("arst_hold", hold_o, 0);
        check_eq("arst_ready", cfg_ready, 1);
        check_eq("arst_write", write, 0);
        check_eq("arst_addr", addr, 0);
        check_eq("arst_wdata", wdata, 0);
        check_eq("arst_cur_mode", cur_mode, 0);
        exp_q.delete();
        d0 = n_done;
        f0 = n_fail;
        repeat (3) @(negedge clk_sys);
        rst = 1'b0;
        repeat (4) @(negedge clk_sys);
        check_eq("arst_no_done", n_done, d0);
        check_eq("arst_no_fail", n_fail, f0);
        push_wr(ZIG_A, 16'h1234);
        push_wr(SEL_A, 16'h0002);
        start_req(2'd2, 16'h1234, a);
        wait_result("post_rst", 1'b1, a + DRAIN + 5 + RB_EXTRA);
        check_eq("post_rst_cur_mode", cur_mode, 2);

`ifdef READBACK_VERIFY_EN
        // First readback corrupted: key write and readback are repeated
        mis_budget = 1;
        push_wr(CAE_A, 16'h0F0F);
        push_wr(CAE_A, 16'h0F0F);
        push_wr(SEL_A, 16'h0000);
        start_req(2'd0, 16'h0F0F, a);
        wait_result("rb_retry", 1'b1, a + DRAIN + 5 + RB_EXTRA + 4);
        check_eq("rb_retry_cur_mode", cur_mode, 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got=running exp=finished");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
